// File: rtl/locked_reg_access_ctrl.sv
// Write-access controller for a bank of lockable configuration registers:
// round-robin arbitration of CPU/debug ports, sticky locks, scan blocking, debug override.
module locked_reg_access_ctrl #(
   parameter int NUM_REGS = 4,
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 2
) (
   input  logic                         Clk,
   input  logic                         reset,
   input  logic                         req0_valid,
   input  logic [ADDR_W-1:0]            req0_addr,
   input  logic [DATA_W-1:0]            req0_data,
   input  logic                         req0_lock,
   output logic                         req0_ready,
   output logic                         req0_resp_valid,
   output logic                         req0_resp_err,
   input  logic                         req1_valid,
   input  logic [ADDR_W-1:0]            req1_addr,
   input  logic [DATA_W-1:0]            req1_data,
   input  logic                         req1_lock,
   output logic                         req1_ready,
   output logic                         req1_resp_valid,
   output logic                         req1_resp_err,
   input  logic                         scan_mode,
   input  logic                         debug_unlocked,
   output logic [NUM_REGS*DATA_W-1:0]   reg_data,
   output logic [NUM_REGS-1:0]          lock_status
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_RESP = 2'd2} state_t;

   state_t              r_state;
   logic                r_ptr;
   logic                r_port;
   logic                r_lock;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_data;
   logic [DATA_W-1:0]   r_regs [NUM_REGS];
   logic [NUM_REGS-1:0] r_lock_st;
   logic                r_resp0_valid;
   logic                r_resp0_err;
   logic                r_resp1_valid;
   logic                r_resp1_err;

   logic                w_gnt_valid;
   logic                w_gnt_port;
   logic [NUM_REGS-1:0] w_hit;
   logic                w_err;

   // Grant selection; r_ptr holds the port favoured when both are requesting.
   always_comb begin
      w_gnt_valid = 1'b0;
      w_gnt_port  = 1'b0;
      if (r_state == S_IDLE) begin
         if (req0_valid && req1_valid) begin
            w_gnt_valid = 1'b1;
            w_gnt_port  = r_ptr;
         end else if (req0_valid) begin
            w_gnt_valid = 1'b1;
            w_gnt_port  = 1'b0;
         end else if (req1_valid) begin
            w_gnt_valid = 1'b1;
            w_gnt_port  = 1'b1;
         end else begin
            w_gnt_valid = 1'b0;
            w_gnt_port  = 1'b0;
         end
      end else begin
         w_gnt_valid = 1'b0;
         w_gnt_port  = 1'b0;
      end
   end

   assign req0_ready = w_gnt_valid & ~w_gnt_port;
   assign req1_ready = w_gnt_valid &  w_gnt_port;

   // Access check for the latched request; an address matching no register is out of range.
   always_comb begin
      w_hit = {NUM_REGS{1'b0}};
      for (int i = 0; i < NUM_REGS; i++) begin
         w_hit[i] = (r_addr == ADDR_W'(i));
      end
      w_err = scan_mode | ~(|w_hit) |
              ((|(w_hit & r_lock_st)) & ~(r_port & debug_unlocked));
   end

   // Request FSM, register bank, sticky locks and registered responses.
   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_ptr         <= 1'b0;
         r_port        <= 1'b0;
         r_lock        <= 1'b0;
         r_addr        <= {ADDR_W{1'b0}};
         r_data        <= {DATA_W{1'b0}};
         r_lock_st     <= {NUM_REGS{1'b0}};
         r_resp0_valid <= 1'b0;
         r_resp0_err   <= 1'b0;
         r_resp1_valid <= 1'b0;
         r_resp1_err   <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= {DATA_W{1'b0}};
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               r_resp0_valid <= 1'b0;
               r_resp0_err   <= 1'b0;
               r_resp1_valid <= 1'b0;
               r_resp1_err   <= 1'b0;
               if (w_gnt_valid) begin
                  r_port  <= w_gnt_port;
                  r_addr  <= w_gnt_port ? req1_addr : req0_addr;
                  r_data  <= w_gnt_port ? req1_data : req0_data;
                  r_lock  <= w_gnt_port ? req1_lock : req0_lock;
                  r_ptr   <= ~w_gnt_port;
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (!w_err) begin
                  for (int i = 0; i < NUM_REGS; i++) begin
                     if (w_hit[i]) begin
                        r_regs[i] <= r_data;
                        if (r_lock) begin
                           r_lock_st[i] <= 1'b1;
                        end
                     end
                  end
               end
               r_resp0_valid <= ~r_port;
               r_resp0_err   <= ~r_port & w_err;
               r_resp1_valid <= r_port;
               r_resp1_err   <= r_port & w_err;
               r_state       <= S_RESP;
            end
            S_RESP: begin
               r_resp0_valid <= 1'b0;
               r_resp0_err   <= 1'b0;
               r_resp1_valid <= 1'b0;
               r_resp1_err   <= 1'b0;
               r_state       <= S_IDLE;
            end
            default: begin
               r_resp0_valid <= 1'b0;
               r_resp0_err   <= 1'b0;
               r_resp1_valid <= 1'b0;
               r_resp1_err   <= 1'b0;
               r_state       <= S_IDLE;
            end
         endcase
      end
   end

   // Flatten the register bank onto the output bus.
   always_comb begin
      reg_data = {(NUM_REGS*DATA_W){1'b0}};
      for (int i = 0; i < NUM_REGS; i++) begin
         reg_data[i*DATA_W +: DATA_W] = r_regs[i];
      end
   end

   assign lock_status     = r_lock_st;
   assign req0_resp_valid = r_resp0_valid;
   assign req0_resp_err   = r_resp0_err;
   assign req1_resp_valid = r_resp1_valid;
   assign req1_resp_err   = r_resp1_err;

endmodule

// File: tb/tb_locked_reg_access_ctrl.sv
// Scoreboard bench for locked_reg_access_ctrl: stimulus pushes expected responses,
// a negedge monitor pops and compares them; register/lock contents checked directly.
module tb_locked_reg_access_ctrl;

   localparam int NR = 3;
   localparam int DW = 16;
   localparam int AW = 2;

   logic            Clk = 1'b0;
   logic            reset = 1'b1;
   logic            req0_valid = 1'b0, req1_valid = 1'b0;
   logic [AW-1:0]   req0_addr = '0, req1_addr = '0;
   logic [DW-1:0]   req0_data = '0, req1_data = '0;
   logic            req0_lock = 1'b0, req1_lock = 1'b0;
   logic            req0_ready, req1_ready;
   logic            req0_resp_valid, req0_resp_err, req1_resp_valid, req1_resp_err;
   logic            scan_mode = 1'b0, debug_unlocked = 1'b0;
   logic [NR*DW-1:0] reg_data;
   logic [NR-1:0]   lock_status;

   typedef struct { logic port; logic err; } exp_t;
   exp_t q[$];

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   locked_reg_access_ctrl #(.NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW)) dut (
      .Clk(Clk), .reset(reset),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
      .req0_lock(req0_lock), .req0_ready(req0_ready),
      .req0_resp_valid(req0_resp_valid), .req0_resp_err(req0_resp_err),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
      .req1_lock(req1_lock), .req1_ready(req1_ready),
      .req1_resp_valid(req1_resp_valid), .req1_resp_err(req1_resp_err),
      .scan_mode(scan_mode), .debug_unlocked(debug_unlocked),
      .reg_data(reg_data), .lock_status(lock_status)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] rd(input int i);
      return reg_data[i*DW +: DW];
   endfunction

   // Scoreboard monitor: every response pulse must match the oldest expectation.
   always @(negedge Clk) begin
      if (!reset && (req0_resp_valid || req1_resp_valid)) begin
         check("resp_one_port", {63'd0, req0_resp_valid & req1_resp_valid}, 64'd0);
         if (q.size() == 0) begin
            check("resp_unexpected", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("resp_port", {63'd0, req1_resp_valid}, {63'd0, e.port});
            check("resp_err", {63'd0, req1_resp_valid ? req1_resp_err : req0_resp_err},
                  {63'd0, e.err});
         end
      end
   end

   // Issue one request, push its expected response, return in the RESP cycle.
   task automatic do_req(input logic p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic l, input logic e, output int waits);
      exp_t x;
      if (p) begin req1_valid = 1'b1; req1_addr = a; req1_data = d; req1_lock = l; end
      else   begin req0_valid = 1'b1; req0_addr = a; req0_data = d; req0_lock = l; end
      #1;
      waits = 0;
      while (!(p ? req1_ready : req0_ready) && waits < 20) begin
         @(negedge Clk); #1;
         waits++;
      end
      if (waits >= 20) begin
         check("ready_timeout", 64'd1, 64'd0);
         req0_valid = 1'b0; req1_valid = 1'b0;
         return;
      end
      @(posedge Clk);
      x.port = p; x.err = e;
      q.push_back(x);
      #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int w;
      int gcount;
      int last_cyc;
      logic [3:0] exp_ports;
      exp_t x;
      exp_ports = 4'b1010;

      repeat (2) @(posedge Clk);
      @(negedge Clk);
      check("rst_reg_data", {16'd0, reg_data}, 64'd0);
      check("rst_lock", {61'd0, lock_status}, 64'd0);
      check("rst_resp", {60'd0, req0_resp_valid, req0_resp_err, req1_resp_valid, req1_resp_err}, 64'd0);
      reset = 1'b0;
      @(negedge Clk);
      check("idle_ready", {62'd0, req0_ready, req1_ready}, 64'd0);

      // 1: plain write, ready in the same cycle
      do_req(1'b0, 2'd1, 16'hA5A5, 1'b0, 1'b0, w);
      check("t1_ready_wait", w, 64'd0);
      check("t1_reg1", rd(1), 64'hA5A5);

      // 2: lock then rejected overwrite
      do_req(1'b0, 2'd2, 16'h1234, 1'b1, 1'b0, w);
      check("t2_lock", {61'd0, lock_status}, 64'h4);
      do_req(1'b0, 2'd2, 16'hFFFF, 1'b0, 1'b1, w);
      check("t2_reg2", rd(2), 64'h1234);

      // 3: debug override, then without authentication
      debug_unlocked = 1'b1;
      do_req(1'b1, 2'd2, 16'hBEEF, 1'b0, 1'b0, w);
      check("t3_reg2_ovr", rd(2), 64'hBEEF);
      check("t3_lock", {61'd0, lock_status}, 64'h4);
      debug_unlocked = 1'b0;
      do_req(1'b1, 2'd2, 16'hCAFE, 1'b0, 1'b1, w);
      check("t3_reg2_noovr", rd(2), 64'hBEEF);

      // 4: scan mode blocks even the debug port
      scan_mode = 1'b1; debug_unlocked = 1'b1;
      do_req(1'b1, 2'd0, 16'h5555, 1'b1, 1'b1, w);
      check("t4_reg0", rd(0), 64'h0);
      check("t4_lock", {61'd0, lock_status}, 64'h4);
      scan_mode = 1'b0; debug_unlocked = 1'b0;

      // 5: both ports held valid; port 1 targets out-of-range addr 3
      req0_valid = 1'b1; req0_addr = 2'd0; req0_data = 16'h1111; req0_lock = 1'b0;
      req1_valid = 1'b1; req1_addr = 2'd3; req1_data = 16'h2222; req1_lock = 1'b0;
      gcount = 0; last_cyc = 0;
      for (int k = 0; k < 40 && gcount < 4; k++) begin
         #1;
         if (req0_ready || req1_ready) begin
            check("t5_grant_port", {63'd0, req1_ready}, {63'd0, exp_ports[gcount]});
            if (gcount > 0) check("t5_grant_gap", cyc - last_cyc, 64'd3);
            last_cyc = cyc;
            @(posedge Clk);
            x.port = req1_ready; x.err = req1_ready;
            q.push_back(x);
            gcount++;
         end
         @(negedge Clk);
      end
      check("t5_grant_count", gcount, 64'd4);
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge Clk); @(negedge Clk);
      check("t5_reg0", rd(0), 64'h1111);
      check("t5_lock", {61'd0, lock_status}, 64'h4);

      // 6: reset during EXEC aborts the write and its response
      req0_valid = 1'b1; req0_addr = 2'd1; req0_data = 16'h7777; req0_lock = 1'b1;
      #1;
      w = 0;
      while (!req0_ready && w < 20) begin @(negedge Clk); #1; w++; end
      check("t6_ready", {63'd0, req0_ready}, 64'd1);
      @(posedge Clk);
      #1 req0_valid = 1'b0;
      #2 reset = 1'b1;
      @(negedge Clk); @(negedge Clk);
      check("t6_reg_data", {16'd0, reg_data}, 64'd0);
      check("t6_lock", {61'd0, lock_status}, 64'd0);
      check("t6_resp", {62'd0, req0_resp_valid, req1_resp_valid}, 64'd0);
      reset = 1'b0;
      repeat (4) @(negedge Clk);
      do_req(1'b0, 2'd1, 16'h9999, 1'b0, 1'b0, w);
      check("t6_reg1_after", rd(1), 64'h9999);
      @(negedge Clk); @(negedge Clk);
      check("queue_empty", q.size(), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
